// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int PC_W        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD,
    HALT
  } state_e;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer, instruction memory, decode and execute.
interface instr_fetch_ctrl_if;
  import fetch_pkg::*;

  logic            fetch_en;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_instr;
  logic [31:0]     instr_out;
  logic [PC_W-1:0] pc_out;
  logic            instr_valid;
  logic            instr_ready;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            misaligned;
  logic            halted;
  logic [31:0]     instr_count;

  modport master (
    input  fetch_en, imem_instr, instr_ready, redirect, redirect_pc,
    output imem_addr, instr_out, pc_out, instr_valid, misaligned, halted, instr_count
  );

  modport slave (
    output fetch_en, imem_instr, instr_ready, redirect, redirect_pc,
    input  imem_addr, instr_out, pc_out, instr_valid, misaligned, halted, instr_count
  );

endinterface

// File: rtl/instr_fetch_ctrl_rd_wait_timer.sv
// Loadable down-counter that times the memory read settle window.
module rd_wait_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, waits out the memory read delay, presents
// instructions to decode with valid/ready, and handles redirects and halting.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] END_PC    = 32'd20,
  parameter int          RD_CYCLES = 2
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_ctrl_if.master bus
);

  localparam int              CNT_W    = $clog2(RD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(RD_CYCLES - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_out_q, pc_out_d;
  logic            valid_q, valid_d;
  logic            misaligned_q, misaligned_d;
  logic [31:0]     count_q, count_d;
  logic            tmr_load;
  logic            tmr_done;
  logic            handshake;

  rd_wait_timer #(.WIDTH(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (LOAD_VAL),
    .tick     (state_q == WAIT),
    .done     (tmr_done)
  );

  assign handshake = valid_q & bus.instr_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    misaligned_d = 1'b0;
    count_d      = count_q;
    tmr_load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.fetch_en) begin
          tmr_load = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (tmr_done) begin
          instr_d  = bus.imem_instr;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + PC_W'(INSTR_BYTES);
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          count_d = count_q + 32'd1;
          valid_d = 1'b0;
          if (pc_out_q == END_PC) begin
            state_d = HALT;
          end else if (bus.fetch_en) begin
            tmr_load = 1'b1;
            state_d  = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Redirect overrides everything above except a same-cycle handshake count.
    if (bus.redirect) begin
      pc_d         = {bus.redirect_pc[PC_W-1:2], 2'b00};
      misaligned_d = |bus.redirect_pc[1:0];
      valid_d      = 1'b0;
      tmr_load     = 1'b1;
      state_d      = bus.fetch_en ? WAIT : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
      misaligned_q <= misaligned_d;
      count_q      <= count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.instr_valid = valid_q;
  assign bus.misaligned  = misaligned_q;
  assign bus.halted      = (state_q == HALT);
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl against a transaction-level model
// of the expected PC stream, instruction words and handshake count.
module tb_instr_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC  = 32'd0;
  localparam logic [31:0] END_PC    = 32'd20;
  localparam int          RD_CYCLES = 2;
  localparam int          LAT       = RD_CYCLES + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  instr_fetch_ctrl_if bus();

  instr_fetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .END_PC    (END_PC),
    .RD_CYCLES (RD_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  assign bus.imem_instr = mem_word(bus.imem_addr);

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_count;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.instr_valid && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic accept();
    $display("xact pc=%08h instr=%08h count_before=%0d", bus.pc_out, bus.instr_out, bus.instr_count);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    exp_count = exp_count + 32'd1;
    exp_pc    = exp_pc + 32'd4;
  endtask

  task automatic test_reset();
    bus.fetch_en = 1'b0; bus.instr_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (bus.imem_addr !== RESET_PC) begin fails++; $display("FAIL rst_addr got=%h exp=%h", bus.imem_addr, RESET_PC); end
    checks++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.instr_out !== 32'd0) begin fails++; $display("FAIL rst_instr got=%h exp=0", bus.instr_out); end
    checks++; if (bus.pc_out !== 32'd0) begin fails++; $display("FAIL rst_pc_out got=%h exp=0", bus.pc_out); end
    checks++; if (bus.misaligned !== 1'b0) begin fails++; $display("FAIL rst_misal got=%b exp=0", bus.misaligned); end
    checks++; if (bus.halted !== 1'b0) begin fails++; $display("FAIL rst_halted got=%b exp=0", bus.halted); end
    checks++; if (bus.instr_count !== 32'd0) begin fails++; $display("FAIL rst_count got=%0d exp=0", bus.instr_count); end
  endtask

  task automatic test_sequential();
    int n;
    bus.fetch_en = 1'b1;
    rst_n = 1'b1;
    exp_pc = RESET_PC; exp_count = 0;
    for (int i = 0; i < 3; i++) begin
      wait_valid(n);
      checks++; if (n != ((i == 0) ? LAT : RD_CYCLES)) begin fails++; $display("FAIL seq_latency[%0d] got=%0d exp=%0d", i, n, (i == 0) ? LAT : RD_CYCLES); end
      checks++; if (bus.pc_out !== exp_pc) begin fails++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.pc_out, exp_pc); end
      checks++; if (bus.instr_out !== mem_word(exp_pc)) begin fails++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, bus.instr_out, mem_word(exp_pc)); end
      accept();
      checks++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL seq_drop[%0d] got=%b exp=0", i, bus.instr_valid); end
    end
    checks++; if (bus.instr_count !== exp_count) begin fails++; $display("FAIL seq_count got=%0d exp=%0d", bus.instr_count, exp_count); end
  endtask

  task automatic test_hold_stall();
    int n;
    wait_valid(n);
    checks++; if (n != RD_CYCLES) begin fails++; $display("FAIL stall_latency got=%0d exp=%0d", n, RD_CYCLES); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.pc_out !== exp_pc || bus.instr_out !== mem_word(exp_pc) || bus.instr_count !== exp_count) begin
        fails++;
        $display("FAIL stall_hold[%0d] got v=%b pc=%h instr=%h cnt=%0d exp v=1 pc=%h instr=%h cnt=%0d",
                 i, bus.instr_valid, bus.pc_out, bus.instr_out, bus.instr_count, exp_pc, mem_word(exp_pc), exp_count);
      end
    end
    accept();
    checks++; if (bus.instr_count !== exp_count) begin fails++; $display("FAIL stall_count got=%0d exp=%0d", bus.instr_count, exp_count); end
    step();
    checks++; if (bus.instr_count !== exp_count) begin fails++; $display("FAIL stall_once got=%0d exp=%0d", bus.instr_count, exp_count); end
  endtask

  task automatic test_redirect_wait();
    int n;
    checks++; if (bus.imem_addr !== exp_pc) begin fails++; $display("FAIL rdw_inflight got=%h exp=%h", bus.imem_addr, exp_pc); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
    step();
    bus.redirect = 1'b0;
    exp_pc = 32'h40;
    checks++; if (bus.imem_addr !== 32'h40) begin fails++; $display("FAIL rdw_addr got=%h exp=00000040", bus.imem_addr); end
    checks++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL rdw_valid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.misaligned !== 1'b0) begin fails++; $display("FAIL rdw_misal got=%b exp=0", bus.misaligned); end
    wait_valid(n);
    checks++; if (n != RD_CYCLES) begin fails++; $display("FAIL rdw_latency got=%0d exp=%0d", n, RD_CYCLES); end
    checks++; if (bus.pc_out !== exp_pc || bus.instr_out !== mem_word(exp_pc)) begin fails++; $display("FAIL rdw_target got pc=%h instr=%h exp pc=%h instr=%h", bus.pc_out, bus.instr_out, exp_pc, mem_word(exp_pc)); end
    accept();
  endtask

  task automatic test_misaligned();
    int n;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h53;
    step();
    bus.redirect = 1'b0;
    exp_pc = 32'h50;
    checks++; if (bus.misaligned !== 1'b1) begin fails++; $display("FAIL mis_pulse got=%b exp=1", bus.misaligned); end
    checks++; if (bus.imem_addr !== 32'h50) begin fails++; $display("FAIL mis_addr got=%h exp=00000050", bus.imem_addr); end
    step();
    checks++; if (bus.misaligned !== 1'b0) begin fails++; $display("FAIL mis_oneshot got=%b exp=0", bus.misaligned); end
    wait_valid(n);
    checks++; if (bus.pc_out !== exp_pc) begin fails++; $display("FAIL mis_pc got=%h exp=%h", bus.pc_out, exp_pc); end
    accept();
  endtask

  task automatic test_redirect_hold();
    int n;
    wait_valid(n);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h80;
    step();
    bus.redirect = 1'b0;
    exp_pc = 32'h80;
    checks++; if (bus.instr_valid !== 1'b0 || bus.instr_count !== exp_count) begin fails++; $display("FAIL rdh_discard got v=%b cnt=%0d exp v=0 cnt=%0d", bus.instr_valid, bus.instr_count, exp_count); end
    wait_valid(n);
    checks++; if (bus.pc_out !== exp_pc) begin fails++; $display("FAIL rdh_pc got=%h exp=%h", bus.pc_out, exp_pc); end
    bus.instr_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
    step();
    bus.instr_ready = 1'b0; bus.redirect = 1'b0;
    exp_count = exp_count + 32'd1;
    exp_pc = 32'h100;
    checks++; if (bus.instr_count !== exp_count) begin fails++; $display("FAIL rdh_same_cycle_count got=%0d exp=%0d", bus.instr_count, exp_count); end
    checks++; if (bus.imem_addr !== exp_pc || bus.instr_valid !== 1'b0) begin fails++; $display("FAIL rdh_same_cycle got addr=%h v=%b exp addr=%h v=0", bus.imem_addr, bus.instr_valid, exp_pc); end
    wait_valid(n);
    checks++; if (bus.pc_out !== exp_pc) begin fails++; $display("FAIL rdh_next_pc got=%h exp=%h", bus.pc_out, exp_pc); end
    accept();
  endtask

  task automatic test_wrap();
    int n;
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    exp_pc = 32'hFFFF_FFFC;
    wait_valid(n);
    checks++; if (bus.pc_out !== exp_pc) begin fails++; $display("FAIL wrap_top got=%h exp=%h", bus.pc_out, exp_pc); end
    accept();
    checks++; if (bus.imem_addr !== 32'd0) begin fails++; $display("FAIL wrap_addr got=%h exp=00000000", bus.imem_addr); end
    wait_valid(n);
    checks++; if (bus.pc_out !== exp_pc) begin fails++; $display("FAIL wrap_zero got=%h exp=%h", bus.pc_out, exp_pc); end
    accept();
  endtask

  task automatic test_halt();
    int n;
    while (exp_pc <= END_PC) begin
      wait_valid(n);
      checks++; if (bus.pc_out !== exp_pc) begin fails++; $display("FAIL halt_seq got=%h exp=%h", bus.pc_out, exp_pc); end
      accept();
    end
    checks++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL halt_flag got=%b exp=1", bus.halted); end
    repeat (6) step();
    checks++; if (bus.imem_addr !== END_PC + 32'd4 || bus.instr_valid !== 1'b0 || bus.halted !== 1'b1) begin
      fails++; $display("FAIL halt_stay got addr=%h v=%b h=%b exp addr=%h v=0 h=1", bus.imem_addr, bus.instr_valid, bus.halted, END_PC + 32'd4);
    end
    bus.redirect = 1'b1; bus.redirect_pc = 32'd0;
    step();
    bus.redirect = 1'b0;
    exp_pc = 32'd0;
    checks++; if (bus.halted !== 1'b0 || bus.imem_addr !== 32'd0) begin fails++; $display("FAIL halt_exit got h=%b addr=%h exp h=0 addr=0", bus.halted, bus.imem_addr); end
    wait_valid(n);
    checks++; if (bus.pc_out !== 32'd0) begin fails++; $display("FAIL halt_resume got=%h exp=0", bus.pc_out); end
    accept();
  endtask

  task automatic test_fetch_en_low();
    int n;
    bus.fetch_en = 1'b0;
    wait_valid(n);
    checks++; if (n != RD_CYCLES || bus.pc_out !== exp_pc) begin fails++; $display("FAIL fen_inflight got n=%0d pc=%h exp n=%0d pc=%h", n, bus.pc_out, RD_CYCLES, exp_pc); end
    accept();
    repeat (8) step();
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== exp_pc) begin fails++; $display("FAIL fen_idle got v=%b addr=%h exp v=0 addr=%h", bus.instr_valid, bus.imem_addr, exp_pc); end
    bus.fetch_en = 1'b1;
    wait_valid(n);
    checks++; if (n != LAT || bus.pc_out !== exp_pc) begin fails++; $display("FAIL fen_resume got n=%0d pc=%h exp n=%0d pc=%h", n, bus.pc_out, LAT, exp_pc); end
    accept();
  endtask

  task automatic test_random();
    int          n;
    int          k;
    logic [31:0] tgt;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h1000;
    step();
    bus.redirect = 1'b0;
    exp_pc = 32'h1000;
    for (int i = 0; i < 30; i++) begin
      wait_valid(n);
      checks++;
      if (n >= 50 || bus.pc_out !== exp_pc || bus.instr_out !== mem_word(exp_pc) || bus.instr_count !== exp_count) begin
        fails++;
        $display("FAIL rnd_present[%0d] got n=%0d pc=%h instr=%h cnt=%0d exp pc=%h instr=%h cnt=%0d",
                 i, n, bus.pc_out, bus.instr_out, bus.instr_count, exp_pc, mem_word(exp_pc), exp_count);
      end
      k = $urandom_range(0, 3);
      for (int s = 0; s < k; s++) begin
        step();
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.pc_out !== exp_pc || bus.instr_count !== exp_count) begin
          fails++; $display("FAIL rnd_stall[%0d] got v=%b pc=%h cnt=%0d exp v=1 pc=%h cnt=%0d", i, bus.instr_valid, bus.pc_out, bus.instr_count, exp_pc, exp_count);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        tgt = 32'h1000 + ($urandom & 32'h0000_FFFF);
        $display("xact pc=%08h instr=%08h redirect_to=%08h", bus.pc_out, bus.instr_out, tgt);
        bus.instr_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = tgt;
        step();
        bus.instr_ready = 1'b0; bus.redirect = 1'b0;
        exp_count = exp_count + 32'd1;
        exp_pc = {tgt[31:2], 2'b00};
        checks++; if (bus.misaligned !== (|tgt[1:0])) begin fails++; $display("FAIL rnd_misal[%0d] got=%b exp=%b", i, bus.misaligned, |tgt[1:0]); end
      end else begin
        accept();
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    step();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.instr_count !== 32'd0 || bus.imem_addr !== RESET_PC || bus.instr_valid !== 1'b0 || bus.halted !== 1'b0) begin
      fails++; $display("FAIL arst_wait got cnt=%0d addr=%h v=%b h=%b exp cnt=0 addr=%h v=0 h=0", bus.instr_count, bus.imem_addr, bus.instr_valid, bus.halted, RESET_PC);
    end
    step();
    rst_n = 1'b1;
    exp_pc = RESET_PC; exp_count = 0;
    wait_valid(n);
    checks++; if (n != LAT || bus.pc_out !== exp_pc) begin fails++; $display("FAIL arst_restart got n=%0d pc=%h exp n=%0d pc=%h", n, bus.pc_out, LAT, exp_pc); end
    accept();
    wait_valid(n);
    checks++; if (bus.pc_out !== exp_pc) begin fails++; $display("FAIL arst_second got=%h exp=%h", bus.pc_out, exp_pc); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.instr_out !== 32'd0 || bus.pc_out !== 32'd0 || bus.instr_count !== 32'd0) begin
      fails++; $display("FAIL arst_hold got v=%b instr=%h pc=%h cnt=%0d exp all zero", bus.instr_valid, bus.instr_out, bus.pc_out, bus.instr_count);
    end
    step();
    rst_n = 1'b1;
    exp_pc = RESET_PC; exp_count = 0;
    wait_valid(n);
    checks++; if (n != LAT || bus.pc_out !== RESET_PC || bus.instr_out !== mem_word(RESET_PC)) begin
      fails++; $display("FAIL arst_refetch got n=%0d pc=%h instr=%h exp n=%0d pc=%h instr=%h", n, bus.pc_out, bus.instr_out, LAT, RESET_PC, mem_word(RESET_PC));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold_stall();
    test_redirect_wait();
    test_misaligned();
    test_redirect_hold();
    test_wrap();
    test_halt();
    test_fetch_en_low();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch sequencer sitting between the program counter and the asynchronous, combinational instruction memory. It owns the PC, drives the memory address, and waits a programmable number of cycles for read data to settle (the memory has a finite read delay). It then presents each instruction to decode through a valid/ready handshake. It also handles branch redirects from execute, and halts at a configured end address.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset.
END_PC, 32'd20, once the instruction at this address is accepted, the block halts.
RD_CYCLES, 2, wait cycles for memory read data to settle; legal range 1..15.

Ports:
clk  in  1  single system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
fetch_en  in  1  permits new fetches to start.
imem_addr  out  32  address to instruction memory; equals the registered PC.
imem_instr  in  32  instruction word returned by memory.
instr_out  out  32  captured instruction presented to decode.
pc_out  out  32  address of instr_out.
instr_valid  out  1  instr_out/pc_out are valid.
instr_ready  in  1  decode accepts instr_out.
redirect  in  1  one-cycle pulse requesting a branch.
redirect_pc  in  32  branch target.
misaligned  out  1  one-cycle pulse: redirect_pc[1:0] was nonzero.
halted  out  1  block is in HALT.
instr_count  out  32  count of completed handshakes.

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - instr_out = 0, pc_out = 0, instr_valid = 0.
  - misaligned = 0, halted = 0, instr_count = 0.
  - wait counter = 0, state = IDLE.
- Reset mid-fetch: the in-flight fetch is discarded with no output glitch beyond the async clear.
- States:
  - IDLE: if fetch_en=1, load cnt = RD_CYCLES-1 and go to WAIT. Otherwise stay in IDLE.
  - WAIT: if cnt != 0, decrement cnt. If cnt == 0:
    - instr_out <= imem_instr, pc_out <= pc, instr_valid <= 1.
    - pc <= pc+4; wraps modulo 2^32, so 32'hFFFFFFFC -> 0.
    - Go to HOLD.
  - HOLD: instr_out, pc_out and instr_valid hold stable until instr_ready=1. On a handshake (valid & ready):
    - instr_count increments.
    - instr_valid drops the next cycle unless a new instruction is being captured.
    - If pc_out == END_PC: go to HALT.
    - Else if fetch_en=1: reload cnt and go to WAIT.
    - Else: go to IDLE.
  - HALT: halted=1, no fetches. Only redirect or reset leaves HALT.
- Latency and throughput:
  - Valid asserts RD_CYCLES cycles after entering WAIT.
  - With instr_ready held high, issue interval is RD_CYCLES+1 cycles per instruction.
- fetch_en deasserted during WAIT: the in-flight fetch completes and presents normally, then the block goes to IDLE after the handshake.
- Redirect: highest priority, taken in every state.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - misaligned pulses for one cycle if redirect_pc[1:0] != 0.
  - instr_valid <= 0; any held or in-flight instruction is discarded.
  - cnt reloads; go to WAIT if fetch_en=1, else IDLE. halted clears.
- Redirect in the same cycle as a HOLD handshake: the handshake counts (instr_count increments, decode owns that instruction), then the redirect applies. The END_PC halt check is suppressed.
- instr_count wraps at 2^32.
- Handshake rule: once instr_valid is high, instr_out and pc_out must not change until the handshake or a redirect.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {IDLE, WAIT, HOLD, HALT};
  - INSTR_BYTES = 4;
  - the PC width constant 32.
- Natural sub-module: rd_wait_timer. It is a loadable down-counter with width $clog2(RD_CYCLES+1), with load/done signals, instantiated once. The rest of the block is the FSM plus PC/output registers.

Test Plan:
- Reset release with fetch_en=1, instr_ready=1, RD_CYCLES=2; memory model returns the word for addresses 0,4,8 -> instr_valid at cycles 2,5,8 with pc_out 0,4,8, instr_count=3 after the third handshake.
- instr_ready=0 for 5 cycles while in HOLD with pc_out=4 -> instr_out and pc_out stable for all 5 cycles; on ready=1 the handshake completes once and instr_count increments by exactly 1.
- Redirect to 32'h10 while in WAIT fetching addr 8 -> instr_valid stays 0, imem_addr=0x10 on the next cycle, next presented pc_out=0x10, no instruction from addr 8 ever appears.
- Redirect to 32'h13 -> misaligned pulses for one cycle, next pc_out=0x10.
- END_PC=20, sequential run -> halted=1 after the handshake at pc_out=20, no further imem_addr change; then redirect to 0 -> halted=0 and fetch resumes at 0.
- Assert rst_n=0 asynchronously mid-WAIT and while in HOLD -> all outputs clear immediately; after release, fetch restarts at RESET_PC.
